shift_pipe: RTL and testbench

Parametrised, pipelined shift/rotate unit: the next generation of the team's 16-bit combinational shifters. It adds a width parameter, rotate modes, a carry-out/zero flag, a tag side-band, and a valid/ready handshake with full back-pressure. It sits between the operand-fetch and writeback stages of the datapath co-processor and replaces separate left, logical-right and arithmetic-right shifter instances with a single unit.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_stage.sv | 59 +++++
 rtl/shift_pipe.sv | 69 ++++++
 tb/tb_shift_pipe.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift_pipe shift/rotate unit: operation encoding
// and the width of the mode field carried down the pipeline.
package shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of shift_pipe: conditionally shifts/rotates by DIST using
// the lowest remaining shamt bit, then registers the record under enable.
module shift_stage
  import shift_pkg::*;
#(
  parameter int  WIDTH   = 16,
  parameter int  DIST    = 1,
  parameter type stage_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  stage_t nxt;

  // Consumed shamt bit is dropped so the next stage always looks at bit 0;
  // carry is overwritten only when this stage actually moves bits out.
  always_comb begin
    nxt       = d;
    nxt.shamt = d.shamt >> 1;
    if (d.shamt[0]) begin
      case (d.mode)
        MODE_SLL: begin
          nxt.data  = d.data << DIST;
          nxt.carry = d.data[WIDTH-DIST];
        end
        MODE_SRL: begin
          nxt.data  = d.data >> DIST;
          nxt.carry = d.data[DIST-1];
        end
        MODE_SRA: begin
          nxt.data  = $unsigned($signed(d.data) >>> DIST);
          nxt.carry = d.data[DIST-1];
        end
        MODE_ROL: begin
          nxt.data  = {d.data[WIDTH-DIST-1:0], d.data[WIDTH-1:WIDTH-DIST]};
          nxt.carry = d.data[WIDTH-DIST];
        end
        MODE_ROR: begin
          nxt.data  = {d.data[DIST-1:0], d.data[WIDTH-1:DIST]};
          nxt.carry = d.data[DIST-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shift/rotate unit with tag side-band and valid/ready handshake;
// stage k shifts by 2^k and the whole pipe stalls when the output is blocked.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  TAG_W = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SW-1:0]     in_shamt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [SW-1:0]     shamt;
    logic [MODE_W-1:0] mode;
    logic [TAG_W-1:0]  tag;
    logic              carry;
    logic              valid;
  } stage_t;

  stage_t pipe [0:SW];
  logic   stall;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  assign pipe[0] = '{data:  in_data,
                     shamt: in_shamt,
                     mode:  in_mode,
                     tag:   in_tag,
                     carry: 1'b0,
                     valid: in_valid};

  for (genvar k = 0; k < SW; k++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .DIST    (1 << k),
      .stage_t (stage_t)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!stall),
      .d     (pipe[k]),
      .q     (pipe[k+1])
    );
  end

  // Zero flag is gated by valid so it reads 0 while the pipe is empty or in reset.
  assign out_valid = pipe[SW].valid;
  assign out_data  = pipe[SW].data;
  assign out_carry = pipe[SW].carry;
  assign out_tag   = pipe[SW].tag;
  assign out_zero  = pipe[SW].valid && (pipe[SW].data == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe at WIDTH = 16, 32 and 4 against a
// whole-shift reference model.
module tb_shift_pipe;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [2:0]  in_mode = '0;
  logic [3:0]  in_tag = '0;
  int          sel = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          wtab [3] = '{16, 32, 4};

  logic [31:0] dir_data [5] = '{32'h8001, 32'h00F0, 32'h8000, 32'h8001, 32'h0009};
  logic [4:0]  dir_sh   [5] = '{5'd1, 5'd4, 5'd15, 5'd1, 5'd4};
  logic [31:0] dir_exp  [5] = '{32'h0002, 32'h000F, 32'hFFFF, 32'h0003, 32'h9000};
  logic        dir_c    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v16i, v32i, v4i;
  logic        r16, r32, r4, ov16, ov32, ov4, c16, c32, c4, z16, z32, z4;
  logic [15:0] d16;
  logic [31:0] d32;
  logic [3:0]  d4, t16, t32, t4;

  assign v16i = in_valid && (sel == 0);
  assign v32i = in_valid && (sel == 1);
  assign v4i  = in_valid && (sel == 2);

  shift_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16i), .in_ready(r16),
    .in_data(in_data[15:0]), .in_shamt(in_shamt[3:0]), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(ov16), .out_ready(out_ready), .out_data(d16), .out_carry(c16),
    .out_zero(z16), .out_tag(t16));

  shift_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32i), .in_ready(r32),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_data(d32), .out_carry(c32),
    .out_zero(z32), .out_tag(t32));

  shift_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4i), .in_ready(r4),
    .in_data(in_data[3:0]), .in_shamt(in_shamt[1:0]), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(ov4), .out_ready(out_ready), .out_data(d4), .out_carry(c4),
    .out_zero(z4), .out_tag(t4));

  logic        cur_in_ready, cur_valid, cur_carry, cur_zero;
  logic [31:0] cur_data;
  logic [3:0]  cur_tag;

  // Present the selected instance's outputs uniformly at 32 bits.
  always_comb begin
    cur_in_ready = r16;
    cur_valid    = ov16;
    cur_data     = {16'd0, d16};
    cur_carry    = c16;
    cur_zero     = z16;
    cur_tag      = t16;
    case (sel)
      1: begin
        cur_in_ready = r32; cur_valid = ov32; cur_data = d32;
        cur_carry = c32; cur_zero = z32; cur_tag = t32;
      end
      2: begin
        cur_in_ready = r4; cur_valid = ov4; cur_data = {28'd0, d4};
        cur_carry = c4; cur_zero = z4; cur_tag = t4;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] mask32(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Reference: the whole shift of s places done in one step.
  function automatic void model(input int w, input logic [31:0] x, input int s,
                                input logic [2:0] m, output logic [31:0] r, output logic c);
    logic [63:0] mask, xv, res;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, x} & mask;
    res  = xv;
    c    = 1'b0;
    if (s != 0) begin
      case (m)
        3'b000: begin res = xv << s; c = xv[w-s]; end
        3'b001: begin res = xv >> s; c = xv[s-1]; end
        3'b010: begin
          res = xv >> s;
          if (xv[w-1]) res = res | (mask & ~(mask >> s));
          c = xv[s-1];
        end
        3'b011: begin res = (xv << s) | (xv >> (w - s)); c = xv[w-s]; end
        3'b100: begin res = (xv >> s) | (xv << (w - s)); c = xv[s-1]; end
        default: ;
      endcase
    end
    res = res & mask;
    r   = res[31:0];
  endfunction

  // Issue one operation into an idle pipe and report what comes out and when.
  task automatic send_op(input logic [31:0] d, input logic [4:0] s, input logic [2:0] m,
                         input logic [3:0] t, output logic [31:0] od, output logic oc,
                         output logic oz, output logic [3:0] ot, output int lat);
    int start;
    @(posedge clk); #1;
    in_data = d; in_shamt = s; in_mode = m; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; od = '0; oc = 1'b0; oz = 1'b0; ot = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_valid) begin
        lat = cyc - start; od = cur_data; oc = cur_carry; oz = cur_zero; ot = cur_tag;
        break;
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd1; in_tag = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      tests++;
      if ({cur_valid, cur_data, cur_carry, cur_zero, cur_tag, cur_in_ready} !==
          {1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
        fails++;
        $display("[TB] FAIL reset_state w%0d: got v=%b d=%h c=%b z=%b t=%h rdy=%b, want 0/0/0/0/0/1",
                 wtab[s], cur_valid, cur_data, cur_carry, cur_zero, cur_tag, cur_in_ready);
      end
    end
    sel = 0;
    @(posedge clk); #2;
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (cur_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_capture cycle %0d: got out_valid=%b, want 0", i, cur_valid);
      end
    end
  endtask

  task automatic test_modes(input int s);
    int w, lat;
    logic [31:0] x, ed, od;
    logic [4:0]  sh;
    logic [2:0]  m;
    logic [3:0]  tg, ot;
    logic        ec, oc, oz;
    sel = s; w = wtab[s];
    for (int i = 0; i < 5; i++) begin
      m = 3'(i);
      if (s == 0) begin
        x = dir_data[i]; sh = dir_sh[i]; ed = dir_exp[i]; ec = dir_c[i];
      end else begin
        x = $urandom & mask32(w);
        sh = 5'($urandom_range(1, w - 1));
        model(w, x, int'(sh), m, ed, ec);
      end
      tg = 4'($urandom);
      send_op(x, sh, m, tg, od, oc, oz, ot, lat);
      tests++;
      if (lat != $clog2(w) || od !== ed || oc !== ec || oz !== (ed == 0) || ot !== tg) begin
        fails++;
        $display("[TB] FAIL mode%0d w%0d x=%h sh=%0d: got d=%h c=%b z=%b t=%h lat=%0d, want d=%h c=%b z=%b t=%h lat=%0d",
                 i, w, x, sh, od, oc, oz, ot, lat, ed, ec, ed == 0, tg, $clog2(w));
      end
    end
  endtask

  task automatic test_shamt_zero();
    int lat;
    logic [31:0] x, ed, od;
    logic [4:0]  sh;
    logic [2:0]  m;
    logic [3:0]  ot;
    logic        oc, oz;
    sel = 0;
    for (int i = 0; i < 11; i++) begin
      x = $urandom & 32'hFFFF; sh = 5'd0; m = 3'(i);
      if (i == 8) begin m = 3'b111; sh = 5'd5; end
      if (i == 9) begin m = 3'b101; sh = 5'd9; end
      if (i == 10) begin m = 3'b000; sh = 5'd3; x = 32'd0; end
      ed = x;
      send_op(x, sh, m, 4'(i), od, oc, oz, ot, lat);
      tests++;
      if (lat != 4 || od !== ed || oc !== 1'b0 || oz !== (ed == 0) || ot !== 4'(i)) begin
        fails++;
        $display("[TB] FAIL passthru mode=%b sh=%0d: got d=%h c=%b z=%b t=%h lat=%0d, want d=%h c=0 z=%b t=%h lat=4",
                 m, sh, od, oc, oz, ot, lat, ed, ed == 0, 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back(input int s);
    exp_t        q [$];
    exp_t        e;
    int          w, sent, got;
    logic        pend, pv, pc, pz;
    logic [31:0] pd;
    logic [3:0]  pt;
    sel = s; w = wtab[s];
    sent = 0; got = 0; pend = 1'b0; pv = 1'b0; pd = '0; pc = 1'b0; pz = 1'b0; pt = '0;
    for (int c = 0; c < 400 && got < 20; c++) begin
      @(posedge clk); #1;
      if (!pend && sent < 20 && $urandom_range(0, 4) != 0) begin
        in_data = $urandom & mask32(w); in_shamt = 5'($urandom_range(0, w - 1));
        in_mode = 3'($urandom_range(0, 5)); in_tag = 4'($urandom);
        in_valid = 1'b1; pend = 1'b1;
      end else if (!pend) begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      tests++;
      if (cur_in_ready !== !(cur_valid && !out_ready)) begin
        fails++;
        $display("[TB] FAIL b2b_in_ready w%0d: got %b, want %b", w, cur_in_ready, !(cur_valid && !out_ready));
      end
      if (pv) begin
        tests++;
        if ({cur_valid, cur_data, cur_carry, cur_zero, cur_tag} !== {1'b1, pd, pc, pz, pt}) begin
          fails++;
          $display("[TB] FAIL b2b_stall_hold w%0d: got v=%b d=%h c=%b z=%b t=%h, want v=1 d=%h c=%b z=%b t=%h",
                   w, cur_valid, cur_data, cur_carry, cur_zero, cur_tag, pd, pc, pz, pt);
        end
      end
      if (in_valid && cur_in_ready) begin
        model(w, in_data, int'(in_shamt), in_mode, e.data, e.carry);
        e.tag = in_tag;
        q.push_back(e);
        sent++; pend = 1'b0;
      end
      if (cur_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("[TB] FAIL b2b_extra w%0d: got unexpected result d=%h, want none", w, cur_data);
        end else begin
          e = q.pop_front();
          if (cur_data !== e.data || cur_carry !== e.carry || cur_zero !== (e.data == 0) || cur_tag !== e.tag) begin
            fails++;
            $display("[TB] FAIL b2b_result w%0d #%0d: got d=%h c=%b z=%b t=%h, want d=%h c=%b z=%b t=%h",
                     w, got, cur_data, cur_carry, cur_zero, cur_tag, e.data, e.carry, e.data == 0, e.tag);
          end
        end
        got++;
      end
      pv = cur_valid && !out_ready; pd = cur_data; pc = cur_carry; pz = cur_zero; pt = cur_tag;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if (got != 20) begin
      fails++;
      $display("[TB] FAIL b2b_count w%0d: got %0d results, want 20", w, got);
    end
  endtask

  task automatic test_stall();
    exp_t e [4];
    sel = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom & 32'hFFFF; in_shamt = 5'($urandom_range(0, 15));
      in_mode = 3'($urandom_range(0, 4)); in_tag = 4'(i + 3); in_valid = 1'b1;
      model(16, in_data, int'(in_shamt), in_mode, e[i].data, e[i].carry);
      e[i].tag = in_tag;
      @(negedge clk);
      tests++;
      if (cur_in_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL stall_fill_ready op%0d: got %b, want 1", i, cur_in_ready);
      end
      @(posedge clk); #1;
    end
    in_data = 32'h1234; in_shamt = 5'd2; in_mode = 3'b000; in_tag = 4'hE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({cur_in_ready, cur_valid, cur_data, cur_carry, cur_tag} !== {1'b0, 1'b1, e[0].data, e[0].carry, e[0].tag}) begin
        fails++;
        $display("[TB] FAIL stall_hold cycle %0d: got rdy=%b v=%b d=%h c=%b t=%h, want rdy=0 v=1 d=%h c=%b t=%h",
                 c, cur_in_ready, cur_valid, cur_data, cur_carry, cur_tag, e[0].data, e[0].carry, e[0].tag);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({cur_valid, cur_data, cur_carry, cur_tag} !== {1'b1, e[i].data, e[i].carry, e[i].tag}) begin
        fails++;
        $display("[TB] FAIL stall_drain op%0d: got v=%b d=%h c=%b t=%h, want v=1 d=%h c=%b t=%h",
                 i, cur_valid, cur_data, cur_carry, cur_tag, e[i].data, e[i].carry, e[i].tag);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (cur_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_extra: got out_valid=%b, want 0", cur_valid);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [31:0] od, ed;
    logic [3:0]  ot;
    logic        oc, oz, ec;
    sel = 0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h00FF << i; in_shamt = 5'd1; in_mode = 3'b001; in_tag = 4'(i + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    tests++;
    if (cur_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL areset_pre: got out_valid=%b, want 1", cur_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cur_valid, cur_data, cur_carry, cur_zero, cur_tag, cur_in_ready} !==
        {1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL areset_clear: got v=%b d=%h c=%b z=%b t=%h rdy=%b, want 0/0/0/0/0/1",
               cur_valid, cur_data, cur_carry, cur_zero, cur_tag, cur_in_ready);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (cur_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL areset_stale cycle %0d: got out_valid=%b t=%h, want 0", i, cur_valid, cur_tag);
      end
    end
    model(16, 32'hA5C3, 3, 3'b011, ed, ec);
    send_op(32'hA5C3, 5'd3, 3'b011, 4'h9, od, oc, oz, ot, lat);
    tests++;
    if (lat != 4 || od !== ed || oc !== ec || ot !== 4'h9) begin
      fails++;
      $display("[TB] FAIL areset_next: got d=%h c=%b t=%h lat=%0d, want d=%h c=%b t=9 lat=4",
               od, oc, ot, lat, ed, ec);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    for (int s = 0; s < 3; s++) begin
      test_modes(s);
      test_back_to_back(s);
    end
    test_shamt_zero();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
